// File: rtl/seq_div.sv
// seq_div -- multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
//
// An operation is issued with a one-cycle start pulse while the unit is in
// IDLE or DONE. The unit then runs WIDTH iterations in CALC, each producing one
// quotient bit. A single FIX cycle follows, which applies the sign and the
// special-case overrides. The result is presented on ans with a one-cycle done
// pulse.
//
// Optional feature macro: SEQ_DIV_FAST_SPECIAL_EN
//   When defined, divide-by-zero and signed overflow skip CALC/FIX. These cases
//   complete one cycle after start, and busy never rises for them. The result
//   values are the same either way.
//
// Ports:
//   clk      in   rising-edge clock
//   rstn     in   asynchronous active-low reset
//   start    in   issue pulse, sampled only in IDLE or DONE
//   op       in   2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   number1  in   dividend (only needs to be valid while start is accepted)
//   number2  in   divisor  (only needs to be valid while start is accepted)
//   busy     out  high during CALC and FIX
//   done     out  one-cycle pulse, ans valid in that cycle
//   ans      out  result register, held until the next completion
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] number1,
  input  logic [WIDTH-1:0] number2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int               CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic             r_op_rem;   // 1 for REM/REMU: return the remainder
  logic [WIDTH-1:0] r_quo;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_n1;       // raw dividend, returned as-is for REM by zero
  logic             r_qsign;
  logic             r_rsign;
  logic             r_div0;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_ans;

  logic             w_signed;
  logic             w_s1;
  logic             w_s2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic             w_div0;
  logic             w_ovf;
  logic             w_bypass;
  logic [WIDTH:0]   w_shift;
  logic             w_borrow;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_fix_res;
  logic [WIDTH-1:0] w_bypass_res;

  // Two's-complement negate when neg is set.
  function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Final result selection. The special cases take priority over whatever the
  // iteration produced.
  function automatic logic [WIDTH-1:0] f_result(input logic             op_rem,
                                                input logic [WIDTH-1:0] quo,
                                                input logic [WIDTH-1:0] rem,
                                                input logic             qsign,
                                                input logic             rsign,
                                                input logic             div0,
                                                input logic             ovf,
                                                input logic [WIDTH-1:0] n1);
    if (div0)
      return op_rem ? n1 : {WIDTH{1'b1}};
    else if (ovf)
      return op_rem ? {WIDTH{1'b0}} : MIN_NEG;
    else if (op_rem)
      return f_cond_neg(rem, rsign);
    else
      return f_cond_neg(quo, qsign);
  endfunction

  // Issue-side decode: signs, magnitudes and special-case detection.
  assign w_signed = ~op[0];
  assign w_s1     = w_signed & number1[WIDTH-1];
  assign w_s2     = w_signed & number2[WIDTH-1];
  assign w_mag1   = f_cond_neg(number1, w_s1);
  assign w_mag2   = f_cond_neg(number2, w_s2);
  assign w_div0   = (number2 == {WIDTH{1'b0}});
  assign w_ovf    = w_signed & (number1 == MIN_NEG) & (number2 == {WIDTH{1'b1}});

`ifdef SEQ_DIV_FAST_SPECIAL_EN
  assign w_bypass = w_div0 | w_ovf;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_bypass_res = f_result(op[1], {WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0, 1'b0,
                                 w_div0, w_ovf, number1);

  // One restoring step. The shifted partial remainder is WIDTH+1 bits wide. If
  // there is no borrow, the difference is below the divisor and fits in WIDTH
  // bits, so a WIDTH-bit subtract is enough.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_borrow = (w_shift < {1'b0, r_div});
  assign w_sub    = w_shift[WIDTH-1:0] - r_div;

  assign w_fix_res = f_result(r_op_rem, r_quo, r_rem, r_qsign, r_rsign,
                              r_div0, r_ovf, r_n1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_op_rem <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_n1     <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
      r_ans    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_op_rem <= op[1];
            r_quo    <= w_mag1;
            r_rem    <= '0;
            r_div    <= w_mag2;
            r_n1     <= number1;
            r_qsign  <= w_s1 ^ w_s2;
            r_rsign  <= w_s1;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            r_cnt    <= '0;
            if (w_bypass) begin
              r_ans   <= w_bypass_res;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        // ---- CALC: one quotient bit per cycle ----
        S_CALC: begin
          r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_sub;
          r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_IT)
            r_state <= S_FIX;
        end
        // ---- FIX: sign correction and special-case override ----
        S_FIX: begin
          r_ans   <= w_fix_res;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign done = (r_state == S_DONE);
  assign ans  = r_ans;

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;
`ifdef SEQ_DIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] number1 = '0;
  logic [W-1:0] number2 = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] ans;

  seq_div #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op),
    .number1(number1), .number2(number2),
    .busy(busy), .done(done), .ans(ans)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] val;
    int           due;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  // Reference: RISC-V M semantics in plain arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : '1;
    if (!o[0] && a == MIN_NEG && b == '1) return o[1] ? '0 : MIN_NEG;
    case (o)
      2'b00:   return W'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return W'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    return (b == 0) || (!o[0] && a == MIN_NEG && b == '1);
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rstn) begin
      if (busy && done) begin
        n_cmp++;
        n_fail++;
        $display("FAIL busy_and_done: got both high expected exclusive");
      end
      if (done) begin
        exp_t e;
        n_done++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done with ans %h expected none", ans);
        end else begin
          e = sbq.pop_front();
          check(e.name, ans, e.val);
          check_int({e.name, "_latency"}, cyc, e.due);
        end
      end
    end
  end

  // Must be called between a falling and a rising edge. Returns just after the
  // accepting edge, with the operand inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string nm);
    exp_t e;
    bit   byp;
    op = o; number1 = a; number2 = b; start = 1'b1;
    byp = FAST && is_special(o, a, b);
    @(posedge clk);
    #1;
    e.val  = model(o, a, b);
    e.due  = cyc + (byp ? 1 : 33);
    e.name = nm;
    sbq.push_back(e);
    start = 1'b0;
    op = 2'($urandom); number1 = $urandom; number2 = $urandom;
    check_int({nm, "_busy"}, int'(busy), byp ? 0 : 1);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (sbq.size() == 0) break;
    end
    if (k == 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (done) break;
    end
    if (k == 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'($urandom_range(1, 20));
      2:       return '1;
      3:       return MIN_NEG;
      4:       return W'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, '0);
    check("reset_done", {31'b0, done}, '0);
    check("reset_ans", ans, '0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed vectors
    issue(2'b01, 32'd100, 32'd7, "divu_100_7");   wait_idle("d1");
    repeat (3) @(negedge clk);
    check("ans_held", ans, 32'd14);
    issue(2'b11, 32'd100, 32'd7, "remu_100_7");   wait_idle("d2");
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2"); wait_idle("d3");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2"); wait_idle("d4");
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2"); wait_idle("d5");
    issue(2'b01, 32'd5, 32'd0, "divu_5_0");       wait_idle("d6");
    issue(2'b10, 32'hFFFF_FFFB, 32'd0, "rem_m5_0"); wait_idle("d7");
    issue(2'b00, MIN_NEG, 32'hFFFF_FFFF, "div_ovf"); wait_idle("d8");
    issue(2'b10, MIN_NEG, 32'hFFFF_FFFF, "rem_ovf"); wait_idle("d9");

    // Back-to-back: second start issued in the DONE cycle
    issue(2'b01, 32'hFFFF_FFFF, 32'd1, "b2b_first");
    wait_done("b2b");
    issue(2'b11, 32'd10, 32'd3, "b2b_second");
    wait_idle("b2b");

    // start during CALC is ignored
    d0 = n_done;
    issue(2'b01, 32'd1000, 32'd10, "ignore_orig");
    repeat (10) @(negedge clk);
    op = 2'b01; number1 = 32'd77; number2 = 32'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("ignore");
    repeat (40) @(negedge clk);
    check_int("ignore_done_count", n_done - d0, 1);

    // Reset in the middle of CALC
    issue(2'b01, 32'd12345, 32'd17, "aborted");
    repeat (15) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, '0);
    check("rst_done", {31'b0, done}, '0);
    check("rst_ans", ans, '0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    issue(2'b01, 32'd9, 32'd3, "after_rst");
    wait_idle("after_rst");

    // Randomized, alternating waits and back-to-back issue
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a, b;
      o = 2'($urandom);
      a = pick();
      b = pick();
      issue(o, a, b, $sformatf("rnd%0d_op%0d", i, o));
      if (i % 3 == 2) begin
        wait_done("rnd_b2b");
      end else begin
        wait_idle("rnd");
      end
    end
    wait_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
